register_bank: RTL and testbench
================================

# register_bank

Parametrised general-purpose register bank; the successor to the fixed four-entry register file. Holds NUM_REGS registers of DATA_BUS_WIDTH bits, two combinational read ports and one write port, and adds in-place increment/decrement with flags, a two-cycle register swap, and a single-cycle clear-all. Sits between the control unit, which issues `op` and selects, and the ALU/data bus, which consumes `reg_1_out`/`reg_2_out`.

## Interface
Parameters:
- DATA_BUS_WIDTH, 8, register and data-bus width (≥2)
- NUM_REGS, 8, register count; power of two, ≥2; SEL_WIDTH = $clog2(NUM_REGS) is a derived localparam

Ports:
- clock  in  1  single clock; all state updates on the falling edge
- reset  in  1  synchronous, active-high; sampled on the falling edge of clock
- op  in  3  bank_op_e (controlpack): NOP=0, WRITE=1, INC=2, DEC=3, SWAP=4, CLEAR=5; 6–7 treated as NOP
- wr_sel  in  SEL_WIDTH  target register for WRITE/INC/DEC; first operand of SWAP
- reg_1_out_sel  in  SEL_WIDTH  read port 1 select
- reg_2_out_sel  in  SEL_WIDTH  read port 2 select; second operand of SWAP
- reg_data_in  in  DATA_BUS_WIDTH  write data
- reg_1_out  out  DATA_BUS_WIDTH  contents of reg[reg_1_out_sel]
- reg_2_out  out  DATA_BUS_WIDTH  contents of reg[reg_2_out_sel]
- busy  out  1  high during the second cycle of SWAP; new ops ignored
- zero_flag  out  1  result of last INC/DEC was zero
- carry_flag  out  1  last INC overflowed / last DEC borrowed

## Operation
- Read ports are combinational from stored state; no write-to-read bypass. A write becomes visible on the outputs only after the falling edge that commits it.
- Reset (reset=1 at falling edge): all registers 0, zero_flag=0, carry_flag=0, busy=0, FSM→IDLE, swap temp=0. Reset wins over any op, including mid-SWAP (swap aborted, no partial value retained).
- FSM states: IDLE, SWAP2.
- IDLE, op decode at falling edge:
  - NOP: no change.
  - WRITE: reg[wr_sel] ← reg_data_in. Flags unchanged.
  - INC: reg[wr_sel] ← reg[wr_sel]+1 mod 2^DATA_BUS_WIDTH; carry_flag ← (old == all-ones); zero_flag ← (result == 0).
  - DEC: reg[wr_sel] ← reg[wr_sel]−1 mod 2^DATA_BUS_WIDTH; carry_flag ← (old == 0); zero_flag ← (result == 0).
  - SWAP: temp ← reg[wr_sel]; reg[wr_sel] ← reg[reg_2_out_sel]; latch reg_2_out_sel as swap target; → SWAP2.
  - CLEAR: all registers 0, both flags 0.
- SWAP2 (busy=1): reg[latched target] ← temp; → IDLE. `op`, selects and data inputs ignored this cycle (except reset).
- SWAP with wr_sel == reg_2_out_sel: register value unchanged, still takes two cycles with busy asserted.
- Flags change only on INC, DEC, CLEAR, reset.

## Timing
- One op accepted per falling edge when busy=0.
- WRITE/INC/DEC/CLEAR: latency 1 edge; result on read ports and flags immediately after that edge.
- SWAP: 2 edges. After edge 1: reg[wr_sel] holds new value, busy=1. After edge 2: both registers swapped, busy=0. Next op accepted at edge 3.
- busy is a registered output, high exactly for the cycle between SWAP edges 1 and 2.
- Reset values of all outputs: reg_1_out=0, reg_2_out=0, busy=0, zero_flag=0, carry_flag=0.

## Test plan
- Reset then WRITE 0xA5 to r3, WRITE 0x5A to r6 → reg_1_out_sel=3 reads 0xA5 after edge, not before; reg_2_out_sel=6 reads 0x5A; other registers 0.
- WRITE 0xFF to r1, INC r1 → r1=0x00, zero_flag=1, carry_flag=1; INC again → r1=0x01, both flags 0; DEC twice → r1=0xFF, carry_flag=1, zero_flag=0.
- r2=0x11, r5=0x22, SWAP (wr_sel=2, reg_2_out_sel=5) → after edge 1 r2=0x22, busy=1; WRITE issued during busy has no effect; after edge 2 r5=0x11, busy=0.
- SWAP r4 with r4 (r4=0x3C) → busy high one cycle, r4 stays 0x3C.
- Reset asserted during SWAP2 → all registers 0, busy=0, flags 0 after that edge; next WRITE accepted normally.
- Fill all NUM_REGS with index+1, CLEAR → every register reads 0, flags 0; op=7 → no state change.

Source files
------------

// File: rtl/register_bank.sv
// Parametrised register bank: two combinational read ports, one write port,
// in-place INC/DEC with flags, two-cycle SWAP and single-cycle CLEAR.
package controlpack;
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_WRITE = 3'd1,
    OP_INC   = 3'd2,
    OP_DEC   = 3'd3,
    OP_SWAP  = 3'd4,
    OP_CLEAR = 3'd5
  } bank_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
  } bank_flags_t;
endpackage

module register_bank_cell #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(negedge clock) begin
    if (reset || clr) q <= '0;
    else if (we)      q <= d;
  end
endmodule

module register_bank
  import controlpack::*;
#(
  parameter int DATA_BUS_WIDTH = 8,
  parameter int NUM_REGS       = 8,
  localparam int SEL_WIDTH     = $clog2(NUM_REGS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [2:0]                op,
  input  logic [SEL_WIDTH-1:0]      wr_sel,
  input  logic [SEL_WIDTH-1:0]      reg_1_out_sel,
  input  logic [SEL_WIDTH-1:0]      reg_2_out_sel,
  input  logic [DATA_BUS_WIDTH-1:0] reg_data_in,
  output logic [DATA_BUS_WIDTH-1:0] reg_1_out,
  output logic [DATA_BUS_WIDTH-1:0] reg_2_out,
  output logic                      busy,
  output logic                      zero_flag,
  output logic                      carry_flag
);
  typedef enum logic {IDLE, SWAP2} state_e;

  state_e                                   state, state_nxt;
  logic [NUM_REGS-1:0][DATA_BUS_WIDTH-1:0]  regs;
  logic [NUM_REGS-1:0]                      we;
  logic [DATA_BUS_WIDTH-1:0]                wdata, old_val, inc_val, dec_val;
  logic [DATA_BUS_WIDTH-1:0]                temp, temp_nxt;
  logic [SEL_WIDTH-1:0]                     swap_tgt, swap_tgt_nxt;
  logic                                     clr_all;
  bank_flags_t                              flags, flags_nxt;

  assign old_val = regs[wr_sel];
  assign inc_val = old_val + 1'b1;
  assign dec_val = old_val - 1'b1;

  // Only one register is written per edge, so all cells share one data bus.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    register_bank_cell #(.W(DATA_BUS_WIDTH)) u_cell (
      .clock (clock),
      .reset (reset),
      .clr   (clr_all),
      .we    (we[i]),
      .d     (wdata),
      .q     (regs[i])
    );
  end

  always_comb begin
    state_nxt    = state;
    we           = '0;
    wdata        = reg_data_in;
    temp_nxt     = temp;
    swap_tgt_nxt = swap_tgt;
    clr_all      = 1'b0;
    flags_nxt    = flags;
    if (state == SWAP2) begin
      we[swap_tgt] = 1'b1;
      wdata        = temp;
      state_nxt    = IDLE;
    end else begin
      case (op)
        OP_WRITE: we[wr_sel] = 1'b1;
        OP_INC: begin
          we[wr_sel]      = 1'b1;
          wdata           = inc_val;
          flags_nxt.zero  = (inc_val == '0);
          flags_nxt.carry = &old_val;
        end
        OP_DEC: begin
          we[wr_sel]      = 1'b1;
          wdata           = dec_val;
          flags_nxt.zero  = (dec_val == '0);
          flags_nxt.carry = (old_val == '0);
        end
        OP_SWAP: begin
          we[wr_sel]   = 1'b1;
          wdata        = regs[reg_2_out_sel];
          temp_nxt     = old_val;
          swap_tgt_nxt = reg_2_out_sel;
          state_nxt    = SWAP2;
        end
        OP_CLEAR: begin
          clr_all   = 1'b1;
          flags_nxt = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      state    <= IDLE;
      temp     <= '0;
      swap_tgt <= '0;
      flags    <= '0;
    end else begin
      state    <= state_nxt;
      temp     <= temp_nxt;
      swap_tgt <= swap_tgt_nxt;
      flags    <= flags_nxt;
    end
  end

  assign reg_1_out  = regs[reg_1_out_sel];
  assign reg_2_out  = regs[reg_2_out_sel];
  assign busy       = (state == SWAP2);
  assign zero_flag  = flags.zero;
  assign carry_flag = flags.carry;
endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank: writes, INC/DEC flags, SWAP timing,
// reset during SWAP, CLEAR and reserved opcodes.
module tb_register_bank;
  localparam int W = 8;
  localparam int N = 8;
  localparam int S = 3;

  logic         clock = 1'b1;
  logic         reset;
  logic [2:0]   op;
  logic [S-1:0] wr_sel, reg_1_out_sel, reg_2_out_sel;
  logic [W-1:0] reg_data_in, reg_1_out, reg_2_out;
  logic         busy, zero_flag, carry_flag;

  int total = 0;
  int bad   = 0;

  register_bank #(.DATA_BUS_WIDTH(W), .NUM_REGS(N)) dut (
    .clock         (clock),
    .reset         (reset),
    .op            (op),
    .wr_sel        (wr_sel),
    .reg_1_out_sel (reg_1_out_sel),
    .reg_2_out_sel (reg_2_out_sel),
    .reg_data_in   (reg_data_in),
    .reg_1_out     (reg_1_out),
    .reg_2_out     (reg_2_out),
    .busy          (busy),
    .zero_flag     (zero_flag),
    .carry_flag    (carry_flag)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, let one falling edge commit them, sample 1ns later.
  task automatic step(input logic [2:0] o, input logic [S-1:0] ws, input logic [W-1:0] d);
    op = o; wr_sel = ws; reg_data_in = d;
    @(negedge clock); #1;
  endtask

  task automatic rd1(input logic [S-1:0] s);
    reg_1_out_sel = s; #1;
  endtask

  initial begin
    reset = 1'b1; op = 3'd0; wr_sel = '0; reg_1_out_sel = '0;
    reg_2_out_sel = 3'd1; reg_data_in = '0;
    step(3'd0, 0, 0);
    chk("rst_r1", reg_1_out, 0);
    chk("rst_r2", reg_2_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_zf", zero_flag, 0);
    chk("rst_cf", carry_flag, 0);
    reset = 1'b0;

    // Write visibility only after the committing edge
    reg_1_out_sel = 3'd3; reg_2_out_sel = 3'd6;
    op = 3'd1; wr_sel = 3'd3; reg_data_in = 8'hA5; #1;
    chk("wr_before_edge", reg_1_out, 0);
    step(3'd1, 3, 8'hA5);
    chk("wr_r3", reg_1_out, 8'hA5);
    step(3'd1, 6, 8'h5A);
    chk("wr_r6", reg_2_out, 8'h5A);
    chk("wr_r3_keep", reg_1_out, 8'hA5);
    for (int i = 0; i < N; i++) begin
      if (i != 3 && i != 6) begin
        rd1(S'(i));
        chk("wr_others_zero", reg_1_out, 0);
      end
    end

    // INC/DEC wrap and flags
    reg_1_out_sel = 3'd1;
    step(3'd1, 1, 8'hFF);
    chk("wr_ff", reg_1_out, 8'hFF);
    chk("wr_flags", {zero_flag, carry_flag}, 2'b00);
    step(3'd2, 1, 8'h00);
    chk("inc_wrap", reg_1_out, 8'h00);
    chk("inc_wrap_flags", {zero_flag, carry_flag}, 2'b11);
    step(3'd2, 1, 8'h00);
    chk("inc_01", reg_1_out, 8'h01);
    chk("inc_01_flags", {zero_flag, carry_flag}, 2'b00);
    step(3'd3, 1, 8'h00);
    chk("dec_00", reg_1_out, 8'h00);
    chk("dec_00_flags", {zero_flag, carry_flag}, 2'b10);
    step(3'd3, 1, 8'h00);
    chk("dec_wrap", reg_1_out, 8'hFF);
    chk("dec_wrap_flags", {zero_flag, carry_flag}, 2'b01);

    // SWAP r2 <-> r5, WRITE during busy is ignored
    step(3'd1, 2, 8'h11);
    step(3'd1, 5, 8'h22);
    reg_1_out_sel = 3'd2; reg_2_out_sel = 3'd5;
    step(3'd4, 2, 8'h00);
    chk("swap1_r2", reg_1_out, 8'h22);
    chk("swap1_r5", reg_2_out, 8'h22);
    chk("swap1_busy", busy, 1);
    reg_2_out_sel = 3'd0;
    step(3'd1, 5, 8'h99);
    chk("swap2_busy", busy, 0);
    rd1(3'd5);
    chk("swap2_r5", reg_1_out, 8'h11);
    rd1(3'd2);
    chk("swap2_r2", reg_1_out, 8'h22);
    step(3'd0, 0, 0);
    rd1(3'd5);
    chk("swap_nowrite_r5", reg_1_out, 8'h11);
    chk("swap_nowrite_r0", reg_2_out, 8'h00);
    chk("swap_flags_kept", {zero_flag, carry_flag}, 2'b01);

    // Self-swap
    step(3'd1, 4, 8'h3C);
    reg_1_out_sel = 3'd4; reg_2_out_sel = 3'd4;
    step(3'd4, 4, 8'h00);
    chk("self_swap_busy", busy, 1);
    chk("self_swap_r4a", reg_1_out, 8'h3C);
    step(3'd0, 0, 0);
    chk("self_swap_idle", busy, 0);
    chk("self_swap_r4b", reg_1_out, 8'h3C);

    // Reset during SWAP2
    reg_2_out_sel = 3'd5;
    step(3'd4, 2, 8'h00);
    chk("rswap_busy", busy, 1);
    reset = 1'b1;
    step(3'd0, 0, 0);
    reset = 1'b0;
    chk("rswap_busy0", busy, 0);
    chk("rswap_flags", {zero_flag, carry_flag}, 2'b00);
    for (int i = 0; i < N; i++) begin
      rd1(S'(i));
      chk("rswap_zero", reg_1_out, 0);
    end
    reg_1_out_sel = 3'd0;
    step(3'd1, 0, 8'h77);
    chk("rswap_write", reg_1_out, 8'h77);

    // Fill, set flags, CLEAR
    step(3'd1, 7, 8'hFF);
    step(3'd2, 7, 8'h00);
    chk("fill_flags", {zero_flag, carry_flag}, 2'b11);
    for (int i = 0; i < N; i++) step(3'd1, S'(i), W'(i + 1));
    for (int i = 0; i < N; i++) begin
      rd1(S'(i));
      chk("fill_val", reg_1_out, i + 1);
    end
    step(3'd5, 0, 0);
    chk("clr_flags", {zero_flag, carry_flag}, 2'b00);
    for (int i = 0; i < N; i++) begin
      rd1(S'(i));
      chk("clr_zero", reg_1_out, 0);
    end

    // Reserved opcodes act as NOP
    step(3'd1, 2, 8'h42);
    step(3'd7, 2, 8'hEE);
    step(3'd6, 3, 8'hEE);
    rd1(3'd2);
    chk("op7_r2", reg_1_out, 8'h42);
    rd1(3'd3);
    chk("op6_r3", reg_1_out, 8'h00);
    chk("op7_busy", busy, 0);
    chk("op7_flags", {zero_flag, carry_flag}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
